// File: rtl/fclk_enable_sequencer.sv
// Round-robin sequencer for fabric clock buffer enables: one EN bit changes at a time,
// and each change is followed by a fixed settle interval before its ACK is updated.
module fclk_enable_sequencer #(
    parameter int unsigned NUM_CLK       = 4,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_CLK-1:0] REQ,
    output logic [NUM_CLK-1:0] EN,
    output logic [NUM_CLK-1:0] ACK,
    output logic               BUSY
);

    localparam int unsigned PtrW = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;
    typedef logic [PtrW-1:0] ptr_t;

    typedef enum logic [0:0] {StIdle, StSettle} state_t;

    state_t             state_q, state_d;
    logic [NUM_CLK-1:0] en_q, en_d;
    logic [NUM_CLK-1:0] ack_q, ack_d;
    ptr_t               ptr_q, ptr_d;
    ptr_t               sel_q, sel_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [NUM_CLK-1:0] pending;
    logic               found;
    ptr_t               pick;

    // First pending domain at or above the pointer, wrapping at NUM_CLK-1.
    always_comb begin
        pending = REQ ^ en_q;
        found   = 1'b0;
        pick    = '0;
        for (int unsigned off = 0; off < NUM_CLK; off++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + off) % NUM_CLK;
            if (!found && pending[ptr_t'(idx)]) begin
                found = 1'b1;
                pick  = ptr_t'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        ack_d   = ack_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    en_d[pick] = ~en_q[pick];
                    sel_d      = pick;
                    cnt_d      = 8'(SETTLE_CYCLES - 1);
                    state_d    = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    ack_d[sel_q] = en_q[sel_q];
                    ptr_d        = (sel_q == ptr_t'(NUM_CLK - 1)) ? '0 : sel_q + ptr_t'(1);
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            en_q    <= '0;
            ack_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign EN   = en_q;
    assign ACK  = ack_q;
    assign BUSY = (state_q == StSettle);

endmodule

// File: tb/tb_fclk_enable_sequencer.sv
// Directed bench for fclk_enable_sequencer: three instances share one clock and cover
// the default configuration, a short settle interval and the single-domain boundary case.
module tb_fclk_enable_sequencer;

    logic       clk;
    logic       rst_a, rst_b, rst_c;
    logic [3:0] req_a, req_b;
    logic [0:0] req_c;
    logic [3:0] en_a, ack_a, en_b, ack_b;
    logic [0:0] en_c, ack_c;
    logic       busy_a, busy_b, busy_c;

    int n_checks = 0;
    int n_fail   = 0;

    fclk_enable_sequencer #(.NUM_CLK(4), .SETTLE_CYCLES(8)) dut_a (
        .CLK(clk), .RST(rst_a), .REQ(req_a), .EN(en_a), .ACK(ack_a), .BUSY(busy_a)
    );
    fclk_enable_sequencer #(.NUM_CLK(4), .SETTLE_CYCLES(4)) dut_b (
        .CLK(clk), .RST(rst_b), .REQ(req_b), .EN(en_b), .ACK(ack_b), .BUSY(busy_b)
    );
    fclk_enable_sequencer #(.NUM_CLK(1), .SETTLE_CYCLES(1)) dut_c (
        .CLK(clk), .RST(rst_c), .REQ(req_c), .EN(en_c), .ACK(ack_c), .BUSY(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [9:0] c_req, c_en, c_ack, c_busy;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        req_a = '0;   req_b = '0;   req_c = '0;
        tick(3);
        chk("a_reset_en", 32'(en_a), 32'h0);
        chk("a_reset_ack", 32'(ack_a), 32'h0);
        chk("a_reset_busy", 32'(busy_a), 32'h0);
        rst_a = 1'b0;
        tick(1);
        chk("a_idle_en", 32'(en_a), 32'h0);

        // Single request on domain 0
        req_a = 4'b0001;
        tick(1);
        chk("single_en", 32'(en_a), 32'h1);
        chk("single_busy", 32'(busy_a), 32'h1);
        tick(7);
        chk("single_busy_t7", 32'(busy_a), 32'h1);
        chk("single_ack_t7", 32'(ack_a), 32'h0);
        tick(1);
        chk("single_ack_t8", 32'(ack_a), 32'h1);
        chk("single_busy_t8", 32'(busy_a), 32'h0);

        // Fresh reset so the pointer is 0, then all four at once
        req_a = '0;
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        req_a = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_v;
            exp_v = 4'((1 << (k + 1)) - 1);
            tick(1);
            chk("rr_en", 32'(en_a), 32'(exp_v));
            tick(8);
            chk("rr_ack", 32'(ack_a), 32'(exp_v));
            chk("rr_busy", 32'(busy_a), 32'h0);
        end

        // Turn off 0,1,3; domain 2 keeps its request
        req_a = 4'b0100;
        tick(1);
        chk("off_en0", 32'(en_a), 32'hE);
        tick(8);
        chk("off_ack0", 32'(ack_a), 32'hE);
        tick(1);
        chk("off_en1", 32'(en_a), 32'hC);
        tick(8);
        tick(1);
        chk("off_en3", 32'(en_a), 32'h4);
        tick(8);
        chk("off_ack_final", 32'(ack_a), 32'h4);
        tick(1);
        chk("off_hold_en", 32'(en_a), 32'h4);
        chk("off_hold_busy", 32'(busy_a), 32'h0);

        // Asynchronous reset in the middle of a settle interval
        req_a = 4'b0101;
        tick(1);
        chk("ar_en_pre", 32'(en_a), 32'h5);
        tick(2);
        #2 rst_a = 1'b1;
        #1;
        chk("ar_en", 32'(en_a), 32'h0);
        chk("ar_ack", 32'(ack_a), 32'h0);
        chk("ar_busy", 32'(busy_a), 32'h0);
        req_a = 4'b0010;
        #1 rst_a = 1'b0;
        tick(1);
        chk("ar_release_en", 32'(en_a), 32'h2);
        chk("ar_release_busy", 32'(busy_a), 32'h1);
        tick(8);
        chk("ar_release_ack", 32'(ack_a), 32'h2);

        // Request reversed mid-settle with SETTLE_CYCLES=4
        rst_b = 1'b0;
        req_b = 4'b0010;
        tick(1);
        chk("rev_en_t", 32'(en_b), 32'h2);
        tick(2);
        req_b = 4'b0000;
        tick(1);
        chk("rev_en_t3", 32'(en_b), 32'h2);
        tick(1);
        chk("rev_ack_t4", 32'(ack_b), 32'h2);
        chk("rev_busy_t4", 32'(busy_b), 32'h0);
        tick(1);
        chk("rev_en_t5", 32'(en_b), 32'h0);
        chk("rev_busy_t5", 32'(busy_b), 32'h1);
        tick(3);
        chk("rev_ack_t8", 32'(ack_b), 32'h2);
        tick(1);
        chk("rev_ack_t9", 32'(ack_b), 32'h0);

        // NUM_CLK=1, SETTLE_CYCLES=1: bit i is the value around edge i+1
        c_req  = 10'b0011010101;
        c_en   = 10'b0011000111;
        c_ack  = 10'b0110001110;
        c_busy = 10'b0101001001;
        rst_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_c = c_req[i];
            tick(1);
            chk($sformatf("one_en_e%0d", i + 1), 32'(en_c), 32'(c_en[i]));
            chk($sformatf("one_ack_e%0d", i + 1), 32'(ack_c), 32'(c_ack[i]));
            chk($sformatf("one_busy_e%0d", i + 1), 32'(busy_c), 32'(c_busy[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
